seg_sequence_monitor: RTL and testbench



---
 rtl/seg_sequence_monitor.sv | 191 +++++++++++++++++++
 tb/tb_seg_sequence_monitor.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_sequence_monitor.sv
// Decodes an active-low 7-segment bus back to BCD and tracks the display ring
// 3,1,8,0,5,7,9,6,2, reporting hold/forward/backward/jump steps and protocol errors.
module seg_sequence_monitor #(
    parameter int STABLE_N = 2,
    parameter int ERR_W    = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sample_en,
    input  logic [6:0]       seg,
    output logic [3:0]       digit,
    output logic             digit_valid,
    output logic             blank,
    output logic [1:0]       step,
    output logic             step_valid,
    output logic             seq_err,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [1:0] {S_SYNC, S_TRACK, S_BLANK} state_t;

    localparam logic [3:0]       STABLE  = 4'(STABLE_N);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_t     state, state_n;
    logic [6:0] last_seg;
    logic [3:0] stable_cnt, cnt_n;
    logic       accept;
    logic [3:0] idx, idx_n;

    logic [3:0] dec_digit;
    logic       dec_ok, dec_blank;
    logic [3:0] ring_idx;
    logic       ring_ok;
    logic [3:0] fwd_idx, bwd_idx;

    logic [3:0] digit_n;
    logic       dv_n, blank_n, sv_n, err_n;
    logic [1:0] step_n;

    always_comb begin
        dec_digit = 4'd0;
        dec_ok    = 1'b1;
        dec_blank = 1'b0;
        case (seg)
            7'b0000001: dec_digit = 4'd0;
            7'b1001111: dec_digit = 4'd1;
            7'b0010010: dec_digit = 4'd2;
            7'b0000110: dec_digit = 4'd3;
            7'b1001100: dec_digit = 4'd4;
            7'b0100100: dec_digit = 4'd5;
            7'b0100000: dec_digit = 4'd6;
            7'b0001111: dec_digit = 4'd7;
            7'b0000000: dec_digit = 4'd8;
            7'b0000100: dec_digit = 4'd9;
            7'b1111111: begin dec_ok = 1'b0; dec_blank = 1'b1; end
            default:    dec_ok = 1'b0;
        endcase
    end

    // Position on the display ring; digit 4 decodes but has no ring slot.
    always_comb begin
        ring_idx = 4'd0;
        ring_ok  = dec_ok;
        case (dec_digit)
            4'd3:    ring_idx = 4'd0;
            4'd1:    ring_idx = 4'd1;
            4'd8:    ring_idx = 4'd2;
            4'd0:    ring_idx = 4'd3;
            4'd5:    ring_idx = 4'd4;
            4'd7:    ring_idx = 4'd5;
            4'd9:    ring_idx = 4'd6;
            4'd6:    ring_idx = 4'd7;
            4'd2:    ring_idx = 4'd8;
            default: ring_ok  = 1'b0;
        endcase
    end

    assign fwd_idx = (idx == 4'd8) ? 4'd0 : idx + 4'd1;
    assign bwd_idx = (idx == 4'd0) ? 4'd8 : idx - 4'd1;

    always_comb begin
        if (seg == last_seg)
            cnt_n = (stable_cnt >= STABLE) ? STABLE : stable_cnt + 4'd1;
        else
            cnt_n = 4'd1;
        accept = sample_en && (cnt_n == STABLE);
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        digit_n = digit;
        dv_n    = digit_valid;
        blank_n = blank;
        step_n  = step;
        sv_n    = 1'b0;
        err_n   = 1'b0;
        if (accept) begin
            dv_n    = dec_ok;
            blank_n = dec_blank;
            if (dec_ok)
                digit_n = dec_digit;
            case (state)
                S_SYNC: begin
                    if (dec_blank) begin
                        state_n = S_BLANK;
                    end else if (ring_ok) begin
                        idx_n   = ring_idx;
                        state_n = S_TRACK;
                    end else begin
                        err_n = 1'b1;
                    end
                end
                S_TRACK: begin
                    if (dec_blank) begin
                        step_n  = 2'b11;
                        sv_n    = 1'b1;
                        state_n = S_BLANK;
                    end else if (ring_ok) begin
                        sv_n  = 1'b1;
                        idx_n = ring_idx;
                        if (ring_idx == idx)
                            step_n = 2'b00;
                        else if (ring_idx == fwd_idx)
                            step_n = 2'b01;
                        else if (ring_idx == bwd_idx)
                            step_n = 2'b10;
                        else begin
                            step_n = 2'b11;
                            err_n  = 1'b1;
                        end
                    end else begin
                        err_n   = 1'b1;
                        state_n = S_SYNC;
                    end
                end
                S_BLANK: begin
                    if (dec_blank) begin
                        state_n = S_BLANK;
                    end else if (ring_ok && ring_idx == 4'd0) begin
                        step_n  = 2'b01;
                        sv_n    = 1'b1;
                        idx_n   = 4'd0;
                        state_n = S_TRACK;
                    end else if (ring_ok) begin
                        err_n   = 1'b1;
                        idx_n   = ring_idx;
                        state_n = S_TRACK;
                    end else begin
                        err_n   = 1'b1;
                        state_n = S_SYNC;
                    end
                end
                default: state_n = S_SYNC;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_SYNC;
            last_seg    <= 7'h7F;
            stable_cnt  <= 4'd0;
            idx         <= 4'd0;
            digit       <= 4'd0;
            digit_valid <= 1'b0;
            blank       <= 1'b0;
            step        <= 2'b00;
            step_valid  <= 1'b0;
            seq_err     <= 1'b0;
            err_count   <= '0;
        end else begin
            if (sample_en) begin
                last_seg   <= seg;
                stable_cnt <= cnt_n;
            end
            state       <= state_n;
            idx         <= idx_n;
            digit       <= digit_n;
            digit_valid <= dv_n;
            blank       <= blank_n;
            step        <= step_n;
            step_valid  <= sv_n;
            seq_err     <= err_n;
            if (err_n && err_count != ERR_MAX)
                err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_seg_sequence_monitor.sv
// Randomised scoreboard bench for seg_sequence_monitor: a history-based reference
// model predicts the registered response to every strobe and reset.
module tb_seg_sequence_monitor;

    localparam int STABLE_N = 2;
    localparam int ERR_W    = 3;
    localparam int ERR_MAX  = (1 << ERR_W) - 1;

    localparam logic [6:0] PAT [0:9] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                          7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                          7'b0000000, 7'b0000100};
    localparam int RING [0:8] = '{3, 1, 8, 0, 5, 7, 9, 6, 2};
    localparam logic [6:0] BLK = 7'b1111111;

    logic             clock = 1'b0;
    logic             reset;
    logic             sample_en;
    logic [6:0]       seg;
    logic [3:0]       digit;
    logic             digit_valid;
    logic             blank;
    logic [1:0]       step;
    logic             step_valid;
    logic             seq_err;
    logic [ERR_W-1:0] err_count;

    seg_sequence_monitor #(.STABLE_N(STABLE_N), .ERR_W(ERR_W)) dut (
        .clock(clock), .reset(reset), .sample_en(sample_en), .seg(seg),
        .digit(digit), .digit_valid(digit_valid), .blank(blank), .step(step),
        .step_valid(step_valid), .seq_err(seq_err), .err_count(err_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit rst;
        int digit, dv, blank, step, sv, serr, errc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    // Reference model: sample history plus ring-position bookkeeping.
    logic [6:0] hist[$];
    int m_state;   // 0 sync, 1 tracking, 2 blank
    int m_p, m_digit, m_dv, m_blank, m_step, m_err;

    function automatic int decode(logic [6:0] s);
        for (int i = 0; i < 10; i++)
            if (s == PAT[i]) return i;
        if (s == BLK) return 10;
        return -1;
    endfunction

    function automatic int ring_pos(int d);
        for (int i = 0; i < 9; i++)
            if (RING[i] == d) return i;
        return -1;
    endfunction

    function automatic exp_t snap(bit rst, int sv, int serr);
        exp_t e;
        e.rst = rst; e.digit = m_digit; e.dv = m_dv; e.blank = m_blank;
        e.step = m_step; e.sv = sv; e.serr = serr; e.errc = m_err;
        return e;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_state = 0; m_p = 0; m_digit = 0; m_dv = 0; m_blank = 0; m_step = 0; m_err = 0;
        q.push_back(snap(1'b1, 0, 0));
    endtask

    task automatic model_strobe(logic [6:0] s);
        int run, d, n, sv, serr;
        sv = 0; serr = 0; run = 0;
        hist.push_back(s);
        if (hist.size() > STABLE_N) void'(hist.pop_front());
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != s) break;
            run++;
        end
        if (run == STABLE_N) begin
            d = decode(s);
            n = (d >= 0 && d < 10) ? ring_pos(d) : -1;
            if (d == 10) begin m_dv = 0; m_blank = 1; end
            else if (d < 0) begin m_dv = 0; m_blank = 0; end
            else begin m_digit = d; m_dv = 1; m_blank = 0; end
            case (m_state)
                0: begin
                    if (d == 10) m_state = 2;
                    else if (n >= 0) begin m_p = n; m_state = 1; end
                    else serr = 1;
                end
                1: begin
                    if (d == 10) begin m_step = 3; sv = 1; m_state = 2; end
                    else if (n < 0) begin serr = 1; m_state = 0; end
                    else begin
                        sv = 1;
                        if (n == m_p) m_step = 0;
                        else if (n == (m_p + 1) % 9) m_step = 1;
                        else if (n == (m_p + 8) % 9) m_step = 2;
                        else begin m_step = 3; serr = 1; end
                        m_p = n;
                    end
                end
                default: begin
                    if (d == 10) ;
                    else if (n == 0) begin m_step = 1; sv = 1; m_p = 0; m_state = 1; end
                    else if (n > 0) begin serr = 1; m_p = n; m_state = 1; end
                    else begin serr = 1; m_state = 0; end
                end
            endcase
            if (serr != 0 && m_err < ERR_MAX) m_err++;
        end
        q.push_back(snap(1'b0, sv, serr));
    endtask

    task automatic tick(bit r, bit en, logic [6:0] s);
        reset = r; sample_en = en; seg = s;
        if (r) model_reset();
        else if (en) model_strobe(s);
        @(negedge clock);
    endtask

    // Strobe a pattern n times with random idle gaps; idle cycles wiggle seg.
    task automatic put(logic [6:0] s, int n);
        for (int i = 0; i < n; i++) begin
            tick(1'b0, 1'b1, s);
            repeat ($urandom_range(0, 2)) tick(1'b0, 1'b0, 7'($urandom));
        end
    endtask

    // Monitor: the cycle after any strobe or reset carries one expected record.
    bit prev_evt = 1'b0;
    always @(posedge clock) prev_evt <= reset | sample_en;

    always @(negedge clock) begin
        exp_t e;
        bit ok;
        if (prev_evt) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL sb_empty: DUT event with no expected record");
            end else begin
                e = q.pop_front();
                ok = !$isunknown({digit, digit_valid, blank, step, step_valid, seq_err, err_count})
                     && int'(digit) == e.digit && int'(digit_valid) == e.dv
                     && int'(blank) == e.blank && int'(step_valid) == e.sv
                     && int'(seq_err) == e.serr && int'(err_count) == e.errc
                     && (!(e.sv != 0 || e.rst) || int'(step) == e.step);
                if (!ok) begin
                    failures++;
                    $display("FAIL record@%0t got dig=%0d dv=%0d blk=%0d stp=%0d sv=%0d err=%0d cnt=%0d need dig=%0d dv=%0d blk=%0d stp=%0d sv=%0d err=%0d cnt=%0d",
                             $time, digit, digit_valid, blank, step, step_valid, seq_err, err_count,
                             e.digit, e.dv, e.blank, e.step, e.sv, e.serr, e.errc);
                end
            end
        end else begin
            checks++;
            if (step_valid !== 1'b0 || seq_err !== 1'b0) begin
                failures++;
                $display("FAIL idle_pulse@%0t got sv=%b err=%b need 0 0", $time, step_valid, seq_err);
            end
        end
    end

    initial begin
        int r, k, nr;
        logic [6:0] s;
        tick(1'b1, 1'b0, BLK);
        tick(1'b1, 1'b0, BLK);

        put(PAT[3], 3);
        for (int i = 0; i < 9; i++) put(PAT[RING[i]], 2);
        put(PAT[3], 2);
        put(PAT[8], 2); put(PAT[1], 2); put(PAT[5], 2); put(PAT[7], 2);
        put(BLK, 2); put(PAT[8], 2); put(BLK, 2); put(PAT[3], 2);
        put(PAT[3], 1); put(PAT[3], 1); put(PAT[5], 1); put(PAT[3], 1); put(PAT[3], 1);
        put(7'b1111110, 2); put(PAT[1], 2);
        for (int i = 0; i < 6; i++) put(PAT[4], 2);
        tick(1'b1, 1'b1, PAT[3]);

        r = 0;
        repeat (500) begin
            k = $urandom_range(0, 99);
            if (k < 1) begin
                tick(1'b1, 1'($urandom_range(0, 1)), 7'($urandom));
                continue;
            end
            if (k < 25)      begin r = (r + 1) % 9; s = PAT[RING[r]]; end
            else if (k < 40) begin r = (r + 8) % 9; s = PAT[RING[r]]; end
            else if (k < 55) s = PAT[RING[r]];
            else if (k < 70) begin r = $urandom_range(0, 8); s = PAT[RING[r]]; end
            else if (k < 80) s = BLK;
            else if (k < 87) s = PAT[4];
            else s = 7'($urandom);
            nr = $urandom_range(1, 3);
            put(s, nr);
        end

        repeat (3) tick(1'b0, 1'b0, BLK);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: %0d records left, need 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
